// File: rtl/otp_keypad_entry.sv
// Keypad front end: collects hex digits into an OTP word and hands it to the OTP comparison FSM.
// Optional inactivity timer enabled by defining OTP_KEYPAD_TIMEOUT_EN.
module otp_keypad_entry #(
  parameter int MAX_DIGITS  = 8,
  parameter int MIN_DIGITS  = 1,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_back,
  input  logic        key_clear,
  input  logic        key_enter,
  output logic        req_access,
  output logic        enter_otp,
  output logic [31:0] user_entered_otp,
  output logic [3:0]  digit_count,
  output logic        busy,
  output logic        timeout
);

  // state     | meaning
  // S_IDLE    | waiting for key_start; last entry held on the outputs
  // S_COLLECT | accepting digit / back / clear / enter keys
  // S_SUB_REQ | req_access pulse to the OTP FSM
  // S_SUB_OTP | enter_otp pulse to the OTP FSM
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUB_REQ, S_SUB_OTP} state_t;

  localparam int          OTP_BITS = 4 * MAX_DIGITS;
  localparam logic [63:0] MASK64   = (64'd1 << OTP_BITS) - 64'd1;
  localparam logic [31:0] OTP_MASK = MASK64[31:0];
  localparam logic [3:0]  MAX_CNT  = 4'(MAX_DIGITS);
  localparam logic [3:0]  MIN_CNT  = 4'(MIN_DIGITS);

  state_t state;
  logic   key_any;

  assign key_any = key_clear | key_back | key_enter | key_valid | key_start;

`ifdef OTP_KEYPAD_TIMEOUT_EN
  localparam int         TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] IDLE_TC = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] idle_cnt;
`else
  // Timer absent: the comparison is false for every legal TIMEOUT_CYC.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      user_entered_otp <= '0;
      digit_count      <= '0;
      req_access       <= 1'b0;
      enter_otp        <= 1'b0;
      busy             <= 1'b0;
`ifdef OTP_KEYPAD_TIMEOUT_EN
      timeout          <= 1'b0;
      idle_cnt         <= '0;
`endif
    end else begin
      req_access <= 1'b0;
      enter_otp  <= 1'b0;
`ifdef OTP_KEYPAD_TIMEOUT_EN
      timeout    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (key_start) begin
            state            <= S_COLLECT;
            user_entered_otp <= '0;
            digit_count      <= '0;
            busy             <= 1'b1;
`ifdef OTP_KEYPAD_TIMEOUT_EN
            idle_cnt         <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (key_clear) begin
            user_entered_otp <= '0;
            digit_count      <= '0;
          end else if (key_back) begin
            if (digit_count != 4'd0) begin
              user_entered_otp <= user_entered_otp >> 4;
              digit_count      <= digit_count - 4'd1;
            end
          end else if (key_enter) begin
            if (digit_count >= MIN_CNT) begin
              state      <= S_SUB_REQ;
              req_access <= 1'b1;
            end
          end else if (key_valid) begin
            if (digit_count < MAX_CNT) begin
              user_entered_otp <= {user_entered_otp[27:0], key_digit} & OTP_MASK;
              digit_count      <= digit_count + 4'd1;
            end
          end else if (key_start) begin
            user_entered_otp <= '0;
            digit_count      <= '0;
          end
`ifdef OTP_KEYPAD_TIMEOUT_EN
          // Any key activity, even an ignored one, restarts the idle window.
          if (key_any) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_TC) begin
            idle_cnt         <= '0;
            timeout          <= 1'b1;
            user_entered_otp <= '0;
            digit_count      <= '0;
            busy             <= 1'b0;
            state            <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        S_SUB_REQ: begin
          state     <= S_SUB_OTP;
          enter_otp <= 1'b1;
        end
        S_SUB_OTP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef OTP_KEYPAD_TIMEOUT_EN
  logic unused_key_any;
  assign unused_key_any = key_any;
`endif

endmodule

// File: tb/tb_otp_keypad_entry.sv
// Testbench for otp_keypad_entry: vector table of directed sequences, then random keys vs a queue model.
module tb_otp_keypad_entry;
  localparam int MAXD = 8;
  localparam int MIND = 1;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst, key_start, key_valid, key_back, key_clear, key_enter;
  logic [3:0]  key_digit;
  logic        req_access, enter_otp, busy, timeout;
  logic [31:0] user_entered_otp;
  logic [3:0]  digit_count;

  otp_keypad_entry #(.MAX_DIGITS(MAXD), .MIN_DIGITS(MIND), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_valid(key_valid), .key_digit(key_digit),
    .key_back(key_back), .key_clear(key_clear), .key_enter(key_enter),
    .req_access(req_access), .enter_otp(enter_otp), .user_entered_otp(user_entered_otp),
    .digit_count(digit_count), .busy(busy), .timeout(timeout));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic r, s, v; logic [3:0] d; logic bk, cl, en;
    logic [31:0] otp; logic [3:0] cnt; logic req, ent, bsy, to;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic r, logic s, logic v, logic [3:0] d, logic bk, logic cl, logic en,
                              logic [31:0] otp, logic [3:0] cnt, logic req, logic ent, logic bsy, logic to);
    vec_t x;
    x.r = r; x.s = s; x.v = v; x.d = d; x.bk = bk; x.cl = cl; x.en = en;
    x.otp = otp; x.cnt = cnt; x.req = req; x.ent = ent; x.bsy = bsy; x.to = to;
    vecs.push_back(x);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic s, logic v, logic [3:0] d, logic bk, logic cl, logic en);
    rst = r; key_start = s; key_valid = v; key_digit = d;
    key_back = bk; key_clear = cl; key_enter = en;
    @(posedge clk);
    #1;
    rst = 0; key_start = 0; key_valid = 0; key_digit = 0;
    key_back = 0; key_clear = 0; key_enter = 0;
  endtask

  task automatic check_all(string tag, logic [31:0] otp, logic [3:0] cnt,
                           logic req, logic ent, logic bsy, logic to);
    chk({tag, ".otp"}, user_entered_otp, otp);
    chk({tag, ".count"}, 32'(digit_count), 32'(cnt));
    chk({tag, ".req_access"}, 32'(req_access), 32'(req));
    chk({tag, ".enter_otp"}, 32'(enter_otp), 32'(ent));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  // Behavioural model: the entry is a queue of digits; submission is a countdown of pending pulses.
  int m_q[$];
  bit m_col;
  int m_left, m_idle;
  bit m_req, m_ent, m_to;

  task automatic model(logic r, logic s, logic v, logic [3:0] d, logic bk, logic cl, logic en);
    bit act;
    m_req = 0; m_ent = 0; m_to = 0;
    act = s | v | bk | cl | en;
    if (r) begin
      m_q.delete(); m_col = 0; m_left = 0; m_idle = 0;
    end else if (m_left > 0) begin
      if (m_left == 2) m_ent = 1;
      m_left--;
    end else if (m_col) begin
      if (cl) m_q.delete();
      else if (bk) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
      end else if (en) begin
        if (m_q.size() >= MIND) begin m_col = 0; m_left = 2; m_req = 1; end
      end else if (v) begin
        if (m_q.size() < MAXD) m_q.push_back(int'(d));
      end else if (s) m_q.delete();
`ifdef OTP_KEYPAD_TIMEOUT_EN
      if (act) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == TO) begin m_to = 1; m_q.delete(); m_col = 0; m_idle = 0; end
      end
`endif
    end else if (s) begin
      m_col = 1; m_q.delete(); m_idle = 0;
    end
  endtask

  function automatic logic [31:0] model_otp();
    logic [31:0] e = 0;
    foreach (m_q[i]) e = (e << 4) | 32'(m_q[i]);
    return e;
  endfunction

  initial begin
    rst = 0; key_start = 0; key_valid = 0; key_digit = 0;
    key_back = 0; key_clear = 0; key_enter = 0;

    // reset
    add(1,0,0,0,0,0,0, 32'h0,0,0,0,0,0);
    // submit 13579, then check hold and ignored digit in IDLE
    add(0,1,0,0,0,0,0, 32'h0,0,0,0,1,0);
    add(0,0,1,1,0,0,0, 32'h1,1,0,0,1,0);
    add(0,0,1,3,0,0,0, 32'h13,2,0,0,1,0);
    add(0,0,1,5,0,0,0, 32'h135,3,0,0,1,0);
    add(0,0,1,7,0,0,0, 32'h1357,4,0,0,1,0);
    add(0,0,1,9,0,0,0, 32'h13579,5,0,0,1,0);
    add(0,0,0,0,0,0,1, 32'h13579,5,1,0,1,0);
    add(0,0,0,0,0,0,0, 32'h13579,5,0,1,1,0);
    add(0,0,0,0,0,0,0, 32'h13579,5,0,0,0,0);
    add(0,0,0,0,0,0,0, 32'h13579,5,0,0,0,0);
    add(0,0,1,2,1,1,1, 32'h13579,5,0,0,0,0);
    // backspace / clear
    add(0,1,0,0,0,0,0, 32'h0,0,0,0,1,0);
    add(0,0,1,1,0,0,0, 32'h1,1,0,0,1,0);
    add(0,0,1,2,0,0,0, 32'h12,2,0,0,1,0);
    add(0,0,1,3,0,0,0, 32'h123,3,0,0,1,0);
    add(0,0,0,0,1,0,0, 32'h12,2,0,0,1,0);
    add(0,0,1,4,0,0,0, 32'h124,3,0,0,1,0);
    add(0,0,0,0,1,0,0, 32'h12,2,0,0,1,0);
    add(0,0,0,0,1,0,0, 32'h1,1,0,0,1,0);
    add(0,0,0,0,1,0,0, 32'h0,0,0,0,1,0);
    add(0,0,0,0,1,0,0, 32'h0,0,0,0,1,0);
    add(0,0,1,1,0,0,0, 32'h1,1,0,0,1,0);
    add(0,0,1,2,0,0,0, 32'h12,2,0,0,1,0);
    add(0,0,0,0,0,1,0, 32'h0,0,0,0,1,0);
    // overflow: 1..8 then a dropped 9
    for (int i = 1; i <= 8; i++) begin
      logic [31:0] acc = 0;
      for (int j = 1; j <= i; j++) acc = (acc << 4) | 32'(j);
      add(0,0,1,4'(i),0,0,0, acc,4'(i),0,0,1,0);
    end
    add(0,0,1,9,0,0,0, 32'h12345678,8,0,0,1,0);
    // enter guard at count 0
    add(0,0,0,0,0,1,0, 32'h0,0,0,0,1,0);
    add(0,0,0,0,0,0,1, 32'h0,0,0,0,1,0);
    add(0,0,0,0,0,0,0, 32'h0,0,0,0,1,0);
    // priority: clear > enter > digit, back > enter, digit > start
    add(0,0,1,5,0,0,0, 32'h5,1,0,0,1,0);
    add(0,0,1,3,0,1,1, 32'h0,0,0,0,1,0);
    add(0,0,0,0,0,0,0, 32'h0,0,0,0,1,0);
    add(0,0,1,2,0,0,0, 32'h2,1,0,0,1,0);
    add(0,0,0,0,1,0,1, 32'h0,0,0,0,1,0);
    add(0,0,1,4,0,0,0, 32'h4,1,0,0,1,0);
    add(0,1,1,6,0,0,0, 32'h46,2,0,0,1,0);
    add(0,1,0,0,0,0,0, 32'h0,0,0,0,1,0);
    // reset during SUB_REQ: no enter_otp afterwards
    add(0,0,1,8,0,0,0, 32'h8,1,0,0,1,0);
    add(0,0,0,0,0,0,1, 32'h8,1,1,0,1,0);
    add(1,0,0,0,0,0,0, 32'h0,0,0,0,0,0);
    add(0,0,0,0,0,0,0, 32'h0,0,0,0,0,0);
    add(0,0,0,0,0,0,0, 32'h0,0,0,0,0,0);
`ifdef OTP_KEYPAD_TIMEOUT_EN
    // 16 idle cycles abandon the entry
    add(0,1,0,0,0,0,0, 32'h0,0,0,0,1,0);
    add(0,0,1,7,0,0,0, 32'h7,1,0,0,1,0);
    for (int i = 0; i < TO - 1; i++) add(0,0,0,0,0,0,0, 32'h7,1,0,0,1,0);
    add(0,0,0,0,0,0,0, 32'h0,0,0,0,0,1);
    add(0,0,0,0,0,0,0, 32'h0,0,0,0,0,0);
    // a key on the 16th cycle suppresses the timeout
    add(0,1,0,0,0,0,0, 32'h0,0,0,0,1,0);
    add(0,0,1,7,0,0,0, 32'h7,1,0,0,1,0);
    for (int i = 0; i < TO - 1; i++) add(0,0,0,0,0,0,0, 32'h7,1,0,0,1,0);
    add(0,0,1,3,0,0,0, 32'h73,2,0,0,1,0);
    for (int i = 0; i < TO - 1; i++) add(0,0,0,0,0,0,0, 32'h73,2,0,0,1,0);
    add(0,0,0,0,0,0,0, 32'h0,0,0,0,0,1);
`else
    add(0,1,0,0,0,0,0, 32'h0,0,0,0,1,0);
    add(0,0,1,7,0,0,0, 32'h7,1,0,0,1,0);
    for (int i = 0; i < 3 * TO; i++) add(0,0,0,0,0,0,0, 32'h7,1,0,0,1,0);
    add(1,0,0,0,0,0,0, 32'h0,0,0,0,0,0);
`endif

    foreach (vecs[i]) begin
      vec_t x = vecs[i];
      drive(x.r, x.s, x.v, x.d, x.bk, x.cl, x.en);
      check_all($sformatf("vec%0d", i), x.otp, x.cnt, x.req, x.ent, x.bsy, x.to);
    end

    // random phase against the queue model
    drive(1,0,0,0,0,0,0);
    model(1,0,0,0,0,0,0);
    begin
      int dense = 1;
      for (int n = 0; n < 4000; n++) begin
        logic r, s, v, bk, cl, en;
        logic [3:0] d;
        if (n % 200 == 0) dense = int'($urandom_range(0, 2) != 0);
        if (dense != 0) begin
          r  = ($urandom_range(0, 199) == 0);
          s  = ($urandom_range(0, 19) == 0);
          v  = ($urandom_range(0, 9) < 4);
          bk = ($urandom_range(0, 9) == 0);
          cl = ($urandom_range(0, 29) == 0);
          en = ($urandom_range(0, 11) == 0);
        end else begin
          r  = 0;
          s  = ($urandom_range(0, 39) == 0);
          v  = ($urandom_range(0, 29) == 0);
          bk = 0; cl = 0;
          en = ($urandom_range(0, 59) == 0);
        end
        d = 4'($urandom_range(0, 15));
        drive(r, s, v, d, bk, cl, en);
        model(r, s, v, d, bk, cl, en);
        check_all("rand", model_otp(), 4'(m_q.size()), m_req, m_ent,
                  m_col || (m_left > 0), m_to);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/otp_keypad_entry.md
# otp_keypad_entry

Keypad front end for the OTP door controller. Collects hex digit keystrokes into a 32-bit OTP word, supports backspace, clear and inactivity timeout, and on the enter key drives the downstream OTP comparison FSM. It emits a one-cycle `req_access` pulse followed by a one-cycle `enter_otp` pulse, and holds `user_entered_otp` stable throughout.

## Interface
- `MAX_DIGITS`, 8: max digits held. Legal range 1..8.
- `MIN_DIGITS`, 1: digits required before enter is accepted. Legal range 1..`MAX_DIGITS`.
- `TIMEOUT_CYC`, 50000000: idle cycles in COLLECT before the entry is abandoned.
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_start` in 1: start/arm key (one-cycle strobe).
- `key_valid` in 1: a digit key strobe is present this cycle.
- `key_digit` in 4: hex digit value, qualified by `key_valid`.
- `key_back` in 1: backspace strobe.
- `key_clear` in 1: clear strobe.
- `key_enter` in 1: enter strobe.
- `req_access` out 1: one-cycle request pulse to the OTP FSM.
- `enter_otp` out 1: one-cycle OTP-entered pulse; fires the cycle after `req_access`.
- `user_entered_otp` out 32: accumulated OTP, right-aligned.
- `digit_count` out 4: digits currently held, 0..`MAX_DIGITS`.
- `busy` out 1: high in COLLECT, SUB_REQ and SUB_OTP.
- `timeout` out 1: one-cycle pulse when an entry is abandoned.

## Operation
- States: IDLE, COLLECT, SUB_REQ, SUB_OTP.
- IDLE:
  - Digit, back, clear and enter keys are ignored.
  - `key_start` → COLLECT, with `user_entered_otp`=0 and `digit_count`=0.
- COLLECT: at most one key action per cycle, priority clear > back > enter > digit.
  - Clear: OTP=0, count=0.
  - Back: if count>0, OTP=OTP>>4 and count−1; at count 0 it is a no-op.
  - Digit: if count<`MAX_DIGITS`, OTP={OTP[27:0],key_digit} and count+1; at `MAX_DIGITS` the digit is dropped silently.
  - Enter: if count≥`MIN_DIGITS` → SUB_REQ; otherwise ignored and the entry is kept.
  - `key_start` in COLLECT restarts the entry (OTP=0, count=0) and stays in COLLECT. It has lower priority than clear/back/enter/digit in the same cycle.
- SUB_REQ: `req_access`=1 → SUB_OTP. All keys ignored.
- SUB_OTP: `enter_otp`=1 → IDLE. All keys ignored.
- Arithmetic: left shift by 4 with zero fill. Bits above 4·`MAX_DIGITS` are always 0.
- `user_entered_otp` and `digit_count` are held unchanged after submission until the next `key_start` or `rst`. The downstream comparison therefore sees a stable value.

## Timing
- Reset values: state IDLE, `user_entered_otp`=0, `digit_count`=0, `req_access`=0, `enter_otp`=0, `busy`=0, `timeout`=0, timeout counter 0.
- All outputs are registered.
- A key strobe at edge n is reflected in `user_entered_otp`/`digit_count` after edge n.
- `key_start` sampled at edge n → `busy`=1 from edge n.
- `key_enter` accepted at edge m:
  - `req_access` high during cycle m+1.
  - `enter_otp` high during cycle m+2.
  - `busy` low from cycle m+3.
  - This satisfies the downstream FSM's request-then-enter ordering on back-to-back cycles.
- Timeout counter:
  - Counts only in COLLECT.
  - Cleared on entry to COLLECT and on any accepted key action (including ignored-digit-at-full).
  - When the counter reaches `TIMEOUT_CYC`−1: `timeout` pulses one cycle, OTP=0, count=0, → IDLE.
  - A key action in the same cycle as expiry wins: the counter clears and there is no timeout.
- `rst` mid-entry or mid-submission: next cycle is IDLE with all reset values. A pending pulse is not emitted.

## Configuration
- `OTP_KEYPAD_TIMEOUT_EN` defined: the inactivity timer and `timeout` behave as above.
- Macro undefined:
  - No counter logic is synthesized.
  - `timeout` is tied 0.
  - COLLECT persists until enter, `key_start` or `rst`.
  - `TIMEOUT_CYC` is unused.

## Test plan
- Submit 13579:
  - Stimulus: `key_start`, digits 1,3,5,7,9, `key_enter`.
  - Response: `user_entered_otp`=32'h00013579, `digit_count`=5; `req_access` pulses 1 cycle after enter, `enter_otp` 2 cycles after, value held afterwards.
- Backspace/clear:
  - Stimulus: `key_start`, digits 1,2,3, `key_back`, digit 4, then `key_back`×3 (count 0, OTP 0), one more `key_back`.
  - Response: OTP=32'h124 after digit 4; count 0 and OTP 0 after the three backs; the extra back is a no-op.
  - Stimulus: digits 1,2, `key_clear`. Response: OTP=0.
- Overflow:
  - Stimulus: 9 digits 1..9 with `MAX_DIGITS`=8.
  - Response: OTP=32'h12345678, count=8, ninth digit dropped.
- Enter guard and priority:
  - Stimulus: `key_enter` at count 0 with `MIN_DIGITS`=1. Response: ignored, stays COLLECT.
  - Stimulus: same-cycle `key_clear`+`key_enter`+digit. Response: OTP=0, no submission.
- Timeout (macro defined, `TIMEOUT_CYC`=16):
  - Stimulus: `key_start`, digit 7, then idle 16 cycles. Response: `timeout` 1-cycle pulse, OTP=0, state IDLE, no `req_access`.
  - Stimulus: a key on cycle 16. Response: timeout suppressed.
- Reset:
  - Stimulus: `rst` asserted in the SUB_REQ cycle.
  - Response: `enter_otp` never asserts; all outputs return to reset values the next cycle.
